// File: rtl/scan_code_sequencer.sv
// rtl/scan_code_sequencer.sv - PS/2 set-2 prefix sequencer with scan-to-ASCII lookup and character FIFO

module scan2ascii (
    input  logic [7:0] scan_code,
    output logic [7:0] ascii_code
);
    always_comb begin
        ascii_code = 8'h00;
        case (scan_code)
            8'h1C: ascii_code = 8'h41;
            8'h32: ascii_code = 8'h42;
            8'h21: ascii_code = 8'h43;
            8'h23: ascii_code = 8'h44;
            8'h24: ascii_code = 8'h45;
            8'h2B: ascii_code = 8'h46;
            8'h34: ascii_code = 8'h47;
            8'h33: ascii_code = 8'h48;
            8'h43: ascii_code = 8'h49;
            8'h3B: ascii_code = 8'h4A;
            8'h42: ascii_code = 8'h4B;
            8'h4B: ascii_code = 8'h4C;
            8'h3A: ascii_code = 8'h4D;
            8'h31: ascii_code = 8'h4E;
            8'h44: ascii_code = 8'h4F;
            8'h4D: ascii_code = 8'h50;
            8'h15: ascii_code = 8'h51;
            8'h2D: ascii_code = 8'h52;
            8'h1B: ascii_code = 8'h53;
            8'h2C: ascii_code = 8'h54;
            8'h3C: ascii_code = 8'h55;
            8'h2A: ascii_code = 8'h56;
            8'h1D: ascii_code = 8'h57;
            8'h22: ascii_code = 8'h58;
            8'h35: ascii_code = 8'h59;
            8'h1A: ascii_code = 8'h5A;
            8'h45: ascii_code = 8'h30;
            8'h16: ascii_code = 8'h31;
            8'h1E: ascii_code = 8'h32;
            8'h26: ascii_code = 8'h33;
            8'h25: ascii_code = 8'h34;
            8'h2E: ascii_code = 8'h35;
            8'h36: ascii_code = 8'h36;
            8'h3D: ascii_code = 8'h37;
            8'h3E: ascii_code = 8'h38;
            8'h46: ascii_code = 8'h39;
            8'h29: ascii_code = 8'h20;
            8'h5A: ascii_code = 8'h0D;
            default: ascii_code = 8'h00;
        endcase
    end
endmodule

module scan_code_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16,
    parameter int REPEAT_EN      = 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               SCAN_VALID,
    input  logic [7:0]         SCAN_DATA,
    output logic [7:0]         ASCII_OUT,
    output logic               ASCII_VALID,
    input  logic               ASCII_READY,
    output logic [FIFO_AW:0]   FIFO_COUNT,
    output logic               OVERFLOW,
    output logic               DROP,
    input  logic               CLR_FLAGS
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK,
        S_LOOKUP
    } state_t;

    state_t              state, state_next;
    logic [7:0]          scan_code;
    logic [7:0]          last_make;
    logic [7:0]          ascii_code;
    logic [TO_W-1:0]     to_cnt;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    count;
    logic                latch_code, clear_last, timeout, in_prefix;
    logic                code_ok, push, pop, full, wr_en, ovf_set, drop_set;

    scan2ascii u_scan2ascii (
        .scan_code  (scan_code),
        .ascii_code (ascii_code)
    );

    assign in_prefix = (state == S_BREAK) || (state == S_EXT) || (state == S_EXT_BREAK);
    assign timeout   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next = state;
        latch_code = 1'b0;
        clear_last = 1'b0;
        case (state)
            S_IDLE: begin
                if (SCAN_VALID) begin
                    if (SCAN_DATA == 8'hF0) begin
                        state_next = S_BREAK;
                    end else if (SCAN_DATA == 8'hE0 || SCAN_DATA == 8'hE1) begin
                        state_next = S_EXT;
                    end else begin
                        latch_code = 1'b1;
                        state_next = S_LOOKUP;
                    end
                end
            end
            S_BREAK: begin
                if (SCAN_VALID) begin
                    clear_last = (SCAN_DATA == last_make);
                    state_next = S_IDLE;
                end else if (timeout) begin
                    state_next = S_IDLE;
                end
            end
            S_EXT: begin
                if (SCAN_VALID) begin
                    state_next = (SCAN_DATA == 8'hF0) ? S_EXT_BREAK : S_IDLE;
                end else if (timeout) begin
                    state_next = S_IDLE;
                end
            end
            S_EXT_BREAK: begin
                if (SCAN_VALID || timeout) begin
                    state_next = S_IDLE;
                end
            end
            S_LOOKUP: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            scan_code <= 8'h00;
            last_make <= 8'h00;
            to_cnt    <= '0;
        end else begin
            state <= state_next;
            if (latch_code) begin
                scan_code <= SCAN_DATA;
            end
            if (clear_last) begin
                last_make <= 8'h00;
            end else if (state == S_LOOKUP && code_ok) begin
                last_make <= scan_code;
            end
            if (state_next != state) begin
                to_cnt <= '0;
            end else if (in_prefix && !SCAN_VALID) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // Only printable characters count as decoded; anything else from the table is ignored.
    assign code_ok  = (ascii_code >= 8'h20) && (ascii_code <= 8'h7E);
    assign push     = (state == S_LOOKUP) && code_ok &&
                      !((REPEAT_EN != 0) && (scan_code == last_make));
    assign full     = (count == (FIFO_AW + 1)'(FIFO_DEPTH));
    assign pop      = (count != '0) && ASCII_READY;
    assign wr_en    = push && (!full || pop);
    assign ovf_set  = push && full && !pop;
    assign drop_set = (state == S_LOOKUP) && SCAN_VALID;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
            DROP     <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= ascii_code;
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
            // Clear wins over a same-cycle set.
            if (CLR_FLAGS) begin
                OVERFLOW <= 1'b0;
                DROP     <= 1'b0;
            end else begin
                if (ovf_set)  OVERFLOW <= 1'b1;
                if (drop_set) DROP     <= 1'b1;
            end
        end
    end

    assign ASCII_OUT   = mem[rd_ptr];
    assign ASCII_VALID = (count != '0);
    assign FIFO_COUNT  = count;

endmodule

// File: doc/scan_code_sequencer.md
# scan_code_sequencer

Sequences raw PS/2 set-2 bytes into the combinational SCAN2ASCII decoder and buffers the resulting characters for the VGA writer. It handles the prefix grammar:
- F0 marks a break.
- E0 and E1 mark an extended code.

Only plain make codes reach the decoder. Auto-repeat makes can be suppressed, and decoded characters are queued in a small show-ahead FIFO with a valid/ready handshake. The block sits between the PS/2 receiver and the VGA writer, and instantiates SCAN2ASCII internally.

## Interface
Parameters:
- FIFO_DEPTH, 8, character FIFO entries; power of two, at least 2.
- FIFO_AW, 3, log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 50000, idle cycles after a prefix before the FSM abandons the sequence.
- TO_W, 16, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.
- REPEAT_EN, 1, 1 = suppress repeated make codes.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SCAN_VALID  in  1  one-cycle strobe; SCAN_DATA holds a received byte.
- SCAN_DATA  in  8  raw PS/2 byte.
- ASCII_OUT  out  8  FIFO head character.
- ASCII_VALID  out  1  FIFO not empty.
- ASCII_READY  in  1  consumer accepts the head when high together with ASCII_VALID.
- FIFO_COUNT  out  FIFO_AW+1  number of occupied entries.
- OVERFLOW  out  1  sticky: a character was lost because the FIFO was full.
- DROP  out  1  sticky: a byte arrived during LOOKUP and was discarded.
- CLR_FLAGS  in  1  synchronous clear of OVERFLOW and DROP.

## Operation
- FSM states: IDLE, BREAK, EXT, EXT_BREAK, LOOKUP.
- IDLE, on SCAN_VALID:
  - F0 goes to BREAK.
  - E0 or E1 goes to EXT.
  - Any other byte is latched into the internal SCAN_CODE register and the FSM goes to LOOKUP.
- BREAK, on SCAN_VALID: if the byte equals LAST_MAKE, LAST_MAKE is cleared to 00. The FSM then goes to IDLE. No output.
- EXT, on SCAN_VALID: F0 goes to EXT_BREAK; any other byte goes to IDLE. Extended makes are discarded.
- EXT_BREAK, on SCAN_VALID: go to IDLE; the byte is discarded.
- LOOKUP, one cycle. The decoder output ASCII_CODE is treated as valid only when it is in the range 20..7E. An unknown (X) value fails the comparison, and the decoder's default branch is a don't-care.
  - The character is pushed when it is valid AND NOT (REPEAT_EN AND SCAN_CODE == LAST_MAKE).
  - On push: if the FIFO is not full, write the character; if it is full, set OVERFLOW and keep the FIFO contents.
  - LAST_MAKE <= SCAN_CODE whenever the code was valid, whether or not the character was pushed.
  - Next state is always IDLE.
- A SCAN_VALID arriving in LOOKUP is discarded and sets DROP.
- Timeout: in BREAK, EXT or EXT_BREAK, the counter increments every cycle without SCAN_VALID. When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE. The counter clears on every state change.
- FIFO: show-ahead. ASCII_OUT shows the head combinationally from the storage array.
  - Pop when ASCII_VALID AND ASCII_READY.
  - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds and OVERFLOW is not set.
  - Pointers are FIFO_AW bits and wrap modulo FIFO_DEPTH. The count is tracked separately, range 0..FIFO_DEPTH.
- CLR_FLAGS has priority over a same-cycle set: the flag reads 0 on the next cycle.
- Reset (async, RESET_N=0) sets:
  - state IDLE, SCAN_CODE=00, LAST_MAKE=00;
  - FIFO pointers and count = 0, so ASCII_VALID=0 and FIFO_COUNT=0;
  - ASCII_OUT=00, with storage cleared;
  - OVERFLOW=0, DROP=0, timeout counter=0.
  Reset mid-sequence abandons any pending prefix and empties the FIFO.

## Timing
- Make byte with SCAN_VALID at edge n:
  - SCAN_CODE is registered at n and the FSM is in LOOKUP during cycle n+1.
  - The FIFO write happens at edge n+1, so ASCII_VALID=1 during cycle n+2 if the FIFO was empty.
  - Latency: 2 cycles from strobe to visible character.
- A pop at edge m updates ASCII_OUT and FIFO_COUNT in cycle m+1.
- Back-to-back SCAN_VALID on consecutive cycles: the second byte falls in LOOKUP and is dropped. Upstream guarantees at least 2 cycles between strobes.
- Timeout exit occurs exactly TIMEOUT_CYCLES cycles after entry to the prefix state when no byte arrives.

## Test plan
- Reset, then SCAN_DATA=1C strobe with ASCII_READY=0 -> ASCII_VALID rises 2 cycles later, ASCII_OUT=41 ('A'), FIFO_COUNT=1; ASCII_READY=1 for one cycle -> ASCII_VALID=0.
- Sequence 16, F0 16, E0 75, E0 F0 75, 05 -> exactly one character 31 ('1') queued; F0, E0 and 05 produce nothing.
- REPEAT_EN=1: 1C,1C,1C -> one 'A'. Then F0 1C, 1C -> second 'A'. Then 32, 1C -> 'B' then 'A'.
- ASCII_READY=0, 9 distinct makes (1C 32 21 23 24 2B 34 33 43) -> FIFO_COUNT=8, OVERFLOW=1, head 41. CLR_FLAGS -> OVERFLOW=0. Push with a simultaneous pop when full -> no OVERFLOW.
- F0, then idle TIMEOUT_CYCLES cycles, then 29 -> 20 (space) queued. F0 then 29 within the window -> nothing queued.
- Strobes 1C and 32 on consecutive cycles -> only 'A' queued, DROP=1. RESET_N low mid-sequence (after E0, with FIFO holding 3) -> all outputs at reset values; next byte 1C -> 'A'.
